// File: rtl/mux_ctrl_pkg.sv
// Shared widths, select/state types and one-hot helper for the mux control arbiter.
package mux_ctrl_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned CNT_W   = 5;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input sel_t s);
        return NUM_SRC'(1) << s;
    endfunction

endpackage

// File: rtl/mux_ctrl_rr_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping 3->0.
module mux_ctrl_rr_pick
    import mux_ctrl_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  sel_t               ptr,
    output logic               found,
    output sel_t               idx
);

    // Scan from farthest offset down so the nearest requester wins.
    always_comb begin
        found = |req;
        idx   = ptr;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[sel_t'(ptr + SEL_W'(i))]) begin
                idx = sel_t'(ptr + SEL_W'(i));
            end
        end
    end

endmodule

// File: rtl/mux_ctrl_arbiter.sv
// Round-robin arbiter driving a registered 4:1 mux select with valid/ready handshake.
// Optional burst hold of up to BURST_LEN beats per grant when MUX_CTRL_BURST_EN is defined.
module mux_ctrl_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   ctrl,
    output logic               out_valid,
    output logic [NUM_SRC-1:0] ack,
    output logic               busy
);

    if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_burst_len
        $error("mux_ctrl_arbiter: BURST_LEN must be in 1..16");
    end

    state_t             state;
    sel_t               ptr;
    logic               accept_c;
    logic               keep_c;
    logic               idle_found;
    sel_t               idle_idx;
    logic               rearb_found;
    sel_t               rearb_idx;
    logic [NUM_SRC-1:0] rearb_req;
    sel_t               next_ptr;

    assign accept_c  = out_valid & out_ready;
    assign rearb_req = req & ~onehot(ctrl);
    assign next_ptr  = sel_t'(ctrl + SEL_W'(1));

    mux_ctrl_rr_pick u_idle_pick (
        .req   (req),
        .ptr   (ptr),
        .found (idle_found),
        .idx   (idle_idx)
    );

    // The current owner is masked out so a lone requester waits one cycle after its accept.
    mux_ctrl_rr_pick u_rearb_pick (
        .req   (rearb_req),
        .ptr   (next_ptr),
        .found (rearb_found),
        .idx   (rearb_idx)
    );

`ifdef MUX_CTRL_BURST_EN
    logic [CNT_W-1:0] beat_cnt;

    assign keep_c = req[ctrl] && ((32'(beat_cnt) + 32'd1) < BURST_LEN);

    // Beats already accepted in the current grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (state == ST_GRANT && accept_c) begin
            beat_cnt <= keep_c ? CNT_W'(beat_cnt + CNT_W'(1)) : '0;
        end
    end
`else
    assign keep_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ctrl      <= '0;
            out_valid <= 1'b0;
            ack       <= '0;
            ptr       <= '0;
            busy      <= 1'b0;
        end else begin
            ack <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (idle_found) begin
                        state     <= ST_GRANT;
                        busy      <= 1'b1;
                        ctrl      <= idle_idx;
                        out_valid <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (accept_c) begin
                        ack <= onehot(ctrl);
                        ptr <= next_ptr;
                        if (!keep_c) begin
                            if (rearb_found) begin
                                ctrl <= rearb_idx;
                            end else begin
                                state     <= ST_IDLE;
                                busy      <= 1'b0;
                                out_valid <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_ctrl_arbiter.sv
// Self-checking bench for mux_ctrl_arbiter: cycle model plus directed literal checks.
// Honours MUX_CTRL_BURST_EN with BURST_LEN = 3.
module tb_mux_ctrl_arbiter;

    localparam int BL = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       out_ready;
    logic [1:0] ctrl;
    logic       out_valid;
    logic [3:0] ack;
    logic       busy;

    int errors = 0;
    int checks = 0;

`ifdef MUX_CTRL_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    mux_ctrl_arbiter #(.BURST_LEN(BL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .out_ready (out_ready),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .ack       (ack),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // First requester at or after start, wrapping; -1 if none.
    function automatic int rr(input int mask, input int start);
        for (int i = 0; i < 4; i++) begin
            if (((mask >> ((start + i) % 4)) & 1) != 0) return (start + i) % 4;
        end
        return -1;
    endfunction

    bit started = 1'b0;
    int m_valid = 0, m_ctrl = 0, m_ptr = 0, m_beats = 0, m_ack = 0;

    // Transaction-level model advanced on each edge, then compared 1 time unit later.
    always @(posedge clk) begin
        int s_req, w;
        bit s_rst, s_rdy;
        s_rst = rst;
        s_req = int'(req);
        s_rdy = out_ready;
        if (s_rst) begin
            started = 1'b1;
            m_valid = 0; m_ctrl = 0; m_ptr = 0; m_beats = 0; m_ack = 0;
        end else if (m_valid == 0) begin
            m_ack = 0;
            w = rr(s_req, m_ptr);
            if (w >= 0) begin
                m_valid = 1; m_ctrl = w; m_beats = 0;
            end
        end else if (s_rdy) begin
            m_ack   = 1 << m_ctrl;
            m_ptr   = (m_ctrl + 1) % 4;
            m_beats = m_beats + 1;
            if (!(BURST && ((s_req >> m_ctrl) & 1) != 0 && m_beats < BL)) begin
                w = rr(s_req & ~(1 << m_ctrl), m_ptr);
                m_beats = 0;
                if (w >= 0) m_ctrl = w;
                else m_valid = 0;
            end
        end else begin
            m_ack = 0;
        end
        #1;
        if (started) begin
            chk("model_ctrl", int'(ctrl), m_ctrl);
            chk("model_valid", int'(out_valid), m_valid);
            chk("model_ack", int'(ack), m_ack);
            chk("model_busy", int'(busy), m_valid);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int exp_rr[5];
        int exp_b[6];
        int nack;
        rst = 1'b1; req = 4'b0000; out_ready = 1'b0;
        step(2);
        chk("rst_ctrl", int'(ctrl), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_ack", int'(ack), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;

        // Single request
        req = 4'b0100; out_ready = 1'b1;
        step(1);
        chk("single_ctrl", int'(ctrl), 2);
        chk("single_valid", int'(out_valid), 1);
        chk("single_busy", int'(busy), 1);
        req = 4'b0000;
        step(1);
        chk("single_ack", int'(ack), 4);
        chk("single_idle", int'(out_valid), 0);
        step(1);
        chk("single_ack_clear", int'(ack), 0);

        // Backpressure
        req = 4'b0001; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_ctrl", int'(ctrl), 0);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_ack", int'(ack), 0);
        end
        out_ready = 1'b1; req = 4'b0000;
        step(1);
        chk("bp_ack_pulse", int'(ack), 1);
        step(1);
        chk("bp_ack_once", int'(ack), 0);
        chk("bp_idle", int'(out_valid), 0);

        // Round robin with all requesting
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b1111; out_ready = 1'b1;
        if (BURST) exp_rr = '{0, 0, 0, 1, 1};
        else       exp_rr = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("rr_ctrl", int'(ctrl), exp_rr[i]);
            chk("rr_valid", int'(out_valid), 1);
        end
        req = 4'b0000;
        step(2);

        // Reset mid-grant
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b1000; out_ready = 1'b0;
        step(1);
        chk("rmid_ctrl", int'(ctrl), 3);
        chk("rmid_valid", int'(out_valid), 1);
        rst = 1'b1; out_ready = 1'b1;
        step(1);
        chk("rmid_rst_valid", int'(out_valid), 0);
        chk("rmid_rst_ctrl", int'(ctrl), 0);
        chk("rmid_rst_ack", int'(ack), 0);
        rst = 1'b0; out_ready = 1'b0;
        step(1);
        chk("rmid_regrant_ctrl", int'(ctrl), 3);
        chk("rmid_regrant_valid", int'(out_valid), 1);
        chk("rmid_no_ack", int'(ack), 0);
        out_ready = 1'b1; req = 4'b0000;
        step(1);
        chk("rmid_ack", int'(ack), 8);
        step(1);

        // Two requesters held: alternation or bursts
        rst = 1'b1; step(1); rst = 1'b0;
        req = 4'b0011; out_ready = 1'b1;
        if (BURST) exp_b = '{0, 0, 0, 1, 1, 1};
        else       exp_b = '{0, 1, 0, 1, 0, 1};
        nack = 0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            if (i < 6) chk("pair_ctrl", int'(ctrl), exp_b[i]);
            if (i >= 1 && ack != 4'b0000) nack++;
        end
        chk("pair_ack_count", nack, 6);
        req = 4'b0000;
        step(2);

        // Lone requester is not regranted in its own accept cycle
        req = 4'b0010; out_ready = 1'b1;
        step(1);
        chk("lone_ctrl", int'(ctrl), 1);
        chk("lone_valid", int'(out_valid), 1);
        step(1);
        if (!BURST) begin
            chk("lone_gap", int'(out_valid), 0);
            chk("lone_ack", int'(ack), 2);
            step(1);
            chk("lone_regrant", int'(out_valid), 1);
        end

        // Mixed directed vectors checked by the model only
        for (int i = 0; i < 16; i++) begin
            req       = 4'(i * 7 + 3);
            out_ready = (i % 3) != 1;
            step(1);
        end
        req = 4'b0000; out_ready = 1'b1;
        step(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
